// File: rtl/serial_subtractor_pkg.sv
// rtl/serial_subtractor_pkg.sv - shared state encodings and width helper for serial_subtractor
package serial_subtractor_pkg;

  // Operation framing: wait for start, walk the bits, present the result for one cycle
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Ceiling log2, used to size the bit counter
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - 1-bit full-subtractor cell
module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic diff,
  output logic borrow
);

  // Difference bit and borrow out of a single bit position
  always_comb begin
    diff   = A ^ B ^ Bin;
    borrow = (~A & B) | (~A & Bin) | (B & Bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial D = A - B - Bin, LSB first, start/busy/done framed
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             ovf
);

  import serial_subtractor_pkg::*;

  // Counter only needs to reach WIDTH-1; the terminal bit is detected before any wrap
  localparam int CW = clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic             accept;
  logic             last_bit;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             bor;
  logic [CW-1:0]    cnt;
  logic             a_msb;
  logic             b_msb;

  logic             cell_diff;
  logic             cell_borrow;
  logic [WIDTH-1:0] res_next;

  // One shared cell works on the current LSB of each operand shift register
  full_subtractor u_cell (
    .A      (a_sh[0]),
    .B      (b_sh[0]),
    .Bin    (bor),
    .diff   (cell_diff),
    .borrow (cell_borrow)
  );

  assign res_next = {cell_diff, res_sh[WIDTH-1:1]};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs; DONE may accept a new start directly
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    last_bit   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        busy = 1'b1;
        if (cnt == LAST_BIT) begin
          last_bit   = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) begin
          accept     = 1'b1;
          state_next = ST_SHIFT;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Operand capture, bit-serial shifting and result/flag registration on the final bit
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      bor    <= 1'b0;
      cnt    <= '0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      D      <= '0;
      Bout   <= 1'b0;
      ovf    <= 1'b0;
    end else if (accept) begin
      a_sh   <= A;
      b_sh   <= B;
      bor    <= Bin;
      res_sh <= '0;
      cnt    <= '0;
      a_msb  <= A[WIDTH-1];
      b_msb  <= B[WIDTH-1];
    end else if (state == ST_SHIFT) begin
      a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
      res_sh <= res_next;
      bor    <= cell_borrow;
      cnt    <= cnt + CW'(1);
      if (last_bit) begin
        D    <= res_next;
        Bout <= cell_borrow;
        // Signed overflow only possible when operand signs differ and the result sign leaves A's
        ovf  <= (a_msb != b_msb) && (cell_diff != a_msb);
      end
    end
  end

endmodule
